// File: rtl/flog_pkg.sv
// Shared widths and operand bundle for the bfloat16 log2 dispatcher.
// The qNaN constant is the forced result when the core never answers.
package flog_pkg;
  localparam int EXP_WIDTH = 8;
  localparam int FRACT_WIDTH = 7;

  typedef struct packed {
    logic                   sign;
    logic [EXP_WIDTH-1:0]   exp;
    logic [FRACT_WIDTH-1:0] fract;
  } flog_t;

  localparam flog_t QNAN = '{
    sign:  1'b0,
    exp:   8'hFF,
    fract: 7'h40
  };
endpackage

// File: rtl/flog_dispatch.sv
// Queues bfloat16 operands and issues them one at a time to a log2 core,
// resetting the core before each issue and forcing a qNaN on timeout.
module flog_dispatch
  import flog_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_sign_i,
  input  logic [EXP_WIDTH-1:0]   in_exp_i,
  input  logic [FRACT_WIDTH-1:0] in_fract_i,
  output logic                   core_rst_o,
  output logic                   core_valid_o,
  output logic                   core_sign_o,
  output logic [EXP_WIDTH-1:0]   core_exp_o,
  output logic [FRACT_WIDTH-1:0] core_fract_o,
  input  logic                   core_valid_i,
  input  logic                   core_s_i,
  input  logic [EXP_WIDTH-1:0]   core_e_i,
  input  logic [FRACT_WIDTH-1:0] core_f_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_sign_o,
  output logic [EXP_WIDTH-1:0]   out_exp_o,
  output logic [FRACT_WIDTH-1:0] out_fract_o,
  output logic                   out_err_o,
  output logic                   busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, CRST, RUN, GAP
  } state_t;

  state_t         state_q, state_d;
  flog_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           live_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  flog_t          head, core_op;
  flog_t          res_q, res_d;
  logic           err_q, err_d;
  logic           out_valid_q;
  logic           push, pop, capture;
  logic           full, empty, out_free;

  assign full     = count_q == (AW+1)'(DEPTH);
  assign empty    = count_q == '0;
  // live_q keeps the input closed during the reset cycle itself
  assign in_ready_o = live_q && !full;
  assign push     = in_valid_i && in_ready_o;
  assign head     = mem[rd_ptr_q];
  assign out_free = !out_valid_q || out_ready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    capture      = 1'b0;
    res_d        = '0;
    err_d        = 1'b0;
    core_rst_o   = 1'b1;
    core_valid_o = 1'b0;
    core_op      = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty && out_free) begin
          state_d = CRST;
          cnt_d   = '0;
        end
      end
      CRST: begin
        core_op = head;
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        core_rst_o   = 1'b0;
        core_valid_o = 1'b1;
        core_op      = head;
        if (core_valid_i) begin
          capture = 1'b1;
          res_d   = '{core_s_i, core_e_i, core_f_i};
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          capture = 1'b1;
          res_d   = QNAN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (capture) begin
          pop     = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (capture) begin
        out_valid_q <= 1'b1;
        res_q       <= res_d;
        err_q       <= err_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{in_sign_i, in_exp_i, in_fract_i};
  end

  assign core_sign_o  = core_op.sign;
  assign core_exp_o   = core_op.exp;
  assign core_fract_o = core_op.fract;
  assign out_valid_o  = out_valid_q;
  assign out_sign_o   = res_q.sign;
  assign out_exp_o    = res_q.exp;
  assign out_fract_o  = res_q.fract;
  assign out_err_o    = err_q;
  assign busy_o = (state_q != IDLE) || !empty || out_valid_q;

endmodule

// File: tb/tb_flog_dispatch.sv
// Directed bench for flog_dispatch with a latency-programmable core stand-in.
// Results are collected at negedge and compared in push order.
module tb_flog_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic       in_sign_i = 1'b0;
  logic [7:0] in_exp_i = '0;
  logic [6:0] in_fract_i = '0;
  logic       core_rst_o, core_valid_o, core_sign_o;
  logic [7:0] core_exp_o;
  logic [6:0] core_fract_o;
  logic       core_valid_i, core_s_i;
  logic [7:0] core_e_i;
  logic [6:0] core_f_i;
  logic       out_valid_o, out_sign_o, out_err_o, busy_o;
  logic       out_ready_i = 1'b1;
  logic [7:0] out_exp_o;
  logic [6:0] out_fract_o;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 3;
  bit mute = 1'b0;
  int run_cyc = 0;
  logic [16:0] got[$];

  flog_dispatch dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_sign_i(in_sign_i), .in_exp_i(in_exp_i),
    .in_fract_i(in_fract_i),
    .core_rst_o(core_rst_o), .core_valid_o(core_valid_o),
    .core_sign_o(core_sign_o), .core_exp_o(core_exp_o),
    .core_fract_o(core_fract_o),
    .core_valid_i(core_valid_i), .core_s_i(core_s_i),
    .core_e_i(core_e_i), .core_f_i(core_f_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_sign_o(out_sign_o), .out_exp_o(out_exp_o),
    .out_fract_o(out_fract_o), .out_err_o(out_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] core_fn(input logic [15:0] op);
    if (op == {1'b0, 8'd143, 7'h7A}) return {1'b0, 8'h7E, 7'h77};
    return {op[15], op[14:7] + 8'd1, op[6:0] ^ 7'h55};
  endfunction

  always @(posedge clk) begin
    if (!core_valid_o) run_cyc <= 0;
    else run_cyc <= run_cyc + 1;
  end

  assign core_valid_i = core_valid_o && !mute && (run_cyc == lat);
  assign {core_s_i, core_e_i, core_f_i} =
    core_fn({core_sign_o, core_exp_o, core_fract_o});

  always @(negedge clk) begin
    if (rst && out_valid_o && out_ready_i)
      got.push_back({out_err_o, out_sign_o, out_exp_o, out_fract_o});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] op);
    in_valid_i = 1'b1;
    {in_sign_i, in_exp_i, in_fract_i} = op;
  endtask

  task automatic push_op(input logic [15:0] op);
    drive(op);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_got(input int n, input int lim, input string tag);
    int c = 0;
    while (got.size() < n && c < lim) begin
      tick();
      c++;
    end
    chk(tag, got.size(), n);
  endtask

  task automatic chk_res(input string tag, input int k,
                         input logic [16:0] exp);
    chk(tag, (got.size() > k) ? got[k] : 17'h1FFFF, exp);
  endtask

  logic [15:0] ops[5];
  logic [15:0] op_a, op_b, op_c, op_d;
  int cyc, runs, seen;

  initial begin
    // reset
    tick();
    tick();
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_core_rst", core_rst_o, 1);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_core_ops", {core_sign_o, core_exp_o, core_fract_o}, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out", {out_err_o, out_sign_o, out_exp_o, out_fract_o}, 0);
    rst = 1'b1;
    tick();
    chk("rdy_after_rst", in_ready_o, 1);

    // single operation, core latency 3
    lat = 3;
    push_op({1'b0, 8'd143, 7'h7A});
    chk("s_busy", busy_o, 1);
    chk("s_idle_crst", core_rst_o, 1);
    tick();
    chk("s_crst1_rst", core_rst_o, 1);
    chk("s_crst1_val", core_valid_o, 0);
    chk("s_crst1_op", {core_exp_o, core_fract_o}, {8'd143, 7'h7A});
    tick();
    chk("s_crst2_rst", core_rst_o, 1);
    tick();
    chk("s_run_rst", core_rst_o, 0);
    chk("s_run_val", core_valid_o, 1);
    chk("s_run_op", {core_sign_o, core_exp_o, core_fract_o},
        {1'b0, 8'd143, 7'h7A});
    tick();
    tick();
    tick();
    chk("s_core_ans", core_valid_i, 1);
    chk("s_not_yet", out_valid_o, 0);
    tick();
    chk("s_out_valid", out_valid_o, 1);
    chk("s_out", {out_err_o, out_sign_o, out_exp_o, out_fract_o},
        {1'b0, 1'b0, 8'h7E, 7'h77});
    chk("s_gap_rst", core_rst_o, 1);
    chk("s_gap_val", core_valid_o, 0);
    tick();
    chk("s_out_clr", out_valid_o, 0);
    chk("s_idle_busy", busy_o, 0);
    chk_res("s_got", 0, {1'b0, 1'b0, 8'h7E, 7'h77});
    got.delete();

    // fill the FIFO with a slow core
    lat = 20;
    for (int i = 0; i < 5; i++)
      ops[i] = {1'(i), 8'(100 + i), 7'(i * 9)};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i]);
      chk("f_ready", in_ready_o, (i < 4) ? 1 : 0);
      tick();
    end
    cyc = 0;
    while (!in_ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("f_pop_wait", cyc, 20);
    tick();
    in_valid_i = 1'b0;
    wait_got(5, 400, "f_count");
    for (int k = 0; k < 5; k++)
      chk_res("f_order", k, {1'b0, core_fn(ops[k])});
    got.delete();

    // backpressure with a queued operand
    lat = 2;
    out_ready_i = 1'b0;
    op_a = {1'b1, 8'd60, 7'h11};
    op_b = {1'b0, 8'd77, 7'h22};
    push_op(op_a);
    push_op(op_b);
    cyc = 0;
    while (!out_valid_o && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("b_valid", out_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold", {out_err_o, out_sign_o, out_exp_o, out_fract_o},
          {1'b0, core_fn(op_a)});
      chk("b_core_rst", core_rst_o, 1);
      chk("b_core_val", core_valid_o, 0);
    end
    out_ready_i = 1'b1;
    tick();
    chk("b_out_clr", out_valid_o, 0);
    chk("b_crst", core_rst_o, 1);
    chk("b_crst_op", {core_sign_o, core_exp_o, core_fract_o}, op_b);
    tick();
    tick();
    chk("b_run", core_valid_o, 1);
    wait_got(2, 50, "b_count");
    chk_res("b_first", 0, {1'b0, core_fn(op_a)});
    chk_res("b_second", 1, {1'b0, core_fn(op_b)});
    got.delete();

    // timeout, then next operand issued
    mute = 1'b1;
    op_c = {1'b0, 8'd10, 7'h05};
    op_d = {1'b1, 8'd200, 7'h7F};
    push_op(op_c);
    push_op(op_d);
    cyc = 0;
    runs = 0;
    while (!out_valid_o && cyc < 300) begin
      runs += int'(core_valid_o);
      tick();
      cyc++;
    end
    chk("t_valid", out_valid_o, 1);
    chk("t_runs", runs, 64);
    chk("t_out", {out_err_o, out_sign_o, out_exp_o, out_fract_o},
        {1'b1, 1'b0, 8'hFF, 7'h40});
    mute = 1'b0;
    lat = 1;
    wait_got(2, 100, "t_count");
    chk_res("t_err_res", 0, {1'b1, 1'b0, 8'hFF, 7'h40});
    chk_res("t_next_res", 1, {1'b0, core_fn(op_d)});
    got.delete();

    // reset during RUN with two operands queued
    lat = 30;
    push_op({1'b0, 8'd1, 7'h01});
    push_op({1'b0, 8'd2, 7'h02});
    push_op({1'b0, 8'd3, 7'h03});
    cyc = 0;
    while (!core_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("r_in_run", core_valid_o, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("r_core_rst", core_rst_o, 1);
    chk("r_core_val", core_valid_o, 0);
    chk("r_core_ops", {core_sign_o, core_exp_o, core_fract_o}, 0);
    chk("r_out", {out_valid_o, out_err_o, out_sign_o, out_exp_o,
                  out_fract_o}, 0);
    chk("r_ready", in_ready_o, 0);
    chk("r_busy", busy_o, 0);
    rst = 1'b1;
    tick();
    chk("r_ready_back", in_ready_o, 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      seen += int'(out_valid_o);
      tick();
    end
    chk("r_no_out", seen, 0);
    chk("r_no_got", got.size(), 0);
    chk("r_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flog_dispatch.md
FLOG_DISPATCH -- requirements
Module: flog_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RST_CYCLES, default 2, cycles core_rst_o is held high before each issue.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles before an error result is forced.
REQ-004 SHALL take EXP_WIDTH (8) and FRACT_WIDTH (7) from flog_pkg.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous reset, active-low.
REQ-007 SHALL have ports in_valid_i in 1, in_ready_o out 1, in_sign_i in 1, in_exp_i in EXP_WIDTH, in_fract_i in FRACT_WIDTH: bfloat16 operand stream.
REQ-008 SHALL have ports core_rst_o out 1 (active-high), core_valid_o out 1, core_sign_o out 1, core_exp_o out EXP_WIDTH, core_fract_o out FRACT_WIDTH: drive the log2 core inputs.
REQ-009 SHALL have ports core_valid_i in 1, core_s_i in 1, core_e_i in EXP_WIDTH, core_f_i in FRACT_WIDTH: core result.
REQ-010 SHALL have ports out_valid_o out 1, out_ready_i in 1, out_sign_o out 1, out_exp_o out EXP_WIDTH, out_fract_o out FRACT_WIDTH, out_err_o out 1: result stream.
REQ-011 SHALL have port busy_o out 1: high whenever state != IDLE or FIFO non-empty or out_valid_o high.

Function
REQ-012 SHALL buffer operands in a DEPTH-entry FIFO; push when in_valid_i && in_ready_o; in_ready_o = !full from registered count.
REQ-013 SHALL reject a push when full even if a pop occurs the same cycle; push and pop in the same non-full cycle SHALL both take effect, count unchanged.
REQ-014 SHALL implement FSM states IDLE, CRST, RUN, GAP.
REQ-015 IDLE -> CRST when FIFO non-empty and output register empty (out_valid_o low, or high with out_ready_i high this cycle).
REQ-016 CRST: core_rst_o=1, core_valid_o=0, core operands = FIFO head; -> RUN after exactly RST_CYCLES cycles.
REQ-017 RUN: core_rst_o=0, core_valid_o=1, core operands = FIFO head held stable.
REQ-018 RUN with core_valid_i=1: capture core_s_i/core_e_i/core_f_i into output register, out_err_o=0, pop FIFO, -> GAP.
REQ-019 RUN with TIMEOUT cycles elapsed and core_valid_i=0: capture {0, 8'hFF, 7'h40} (qNaN), out_err_o=1, pop FIFO, -> GAP.
REQ-020 GAP: exactly one cycle, core_valid_o=0, core_rst_o=1; -> IDLE.
REQ-021 core_rst_o SHALL be 1 in IDLE, CRST, GAP; 0 only in RUN.
REQ-022 core_valid_i outside RUN SHALL be ignored.
REQ-023 out_valid_o SHALL rise the cycle after capture; output fields SHALL stay stable while out_valid_o && !out_ready_i; out_valid_o clears after a cycle with out_ready_i=1.
REQ-024 Latency: push accepted at edge N into empty FIFO with IDLE and empty output -> CRST from N+1, RUN from N+1+RST_CYCLES; capture edge M -> out_valid_o high from M.
REQ-025 Only one operation in flight; results SHALL emerge in push order.

Reset
REQ-026 While rst=0 at a clock edge: state IDLE, FIFO empty, timeout counter 0, out_valid_o=0, out_err_o=0, out data 0, core_valid_o=0, core operands 0, core_rst_o=1, in_ready_o=0, busy_o=0.
REQ-027 Reset SHALL abort any RUN/CRST in progress; the in-flight operand and any pending result SHALL be discarded.
REQ-028 in_ready_o SHALL be 1 from the first cycle after rst returns high.

Verification
REQ-029 Single op: push {0,143,7'h7A}; core model answers {0,8'h7E,7'h77} 3 cycles after core_valid_o rises -> core_rst_o high exactly 2 cycles, core operands 143/7'h7A, out {0,8'h7E,7'h77}, out_err_o=0, GAP then IDLE.
REQ-030 Fill: core latency 20, out_ready_i=1, push 5 back-to-back -> 4 accepted, in_ready_o=0 until first capture pop, 5 results in push order.
REQ-031 Backpressure: out_ready_i=0 with result held and FIFO non-empty -> out fields stable, state stays IDLE, core_rst_o=1; out_ready_i=1 -> CRST next cycle.
REQ-032 Timeout: core never answers -> after 64 RUN cycles out {0,8'hFF,7'h40}, out_err_o=1, next operand then issued.
REQ-033 Reset mid-RUN: rst=0 for one edge during RUN with 2 operands queued -> all outputs at reset values next cycle, no result ever emitted for the discarded operands.
REQ-034 Full boundary: FIFO full, in_valid_i=1 on the pop cycle -> push rejected that cycle, accepted the next.
